// File: rtl/muldiv_hilo_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One multiplier or quotient bit per cycle: 32 CALC cycles plus one FIX cycle for sign correction.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_DW = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]         state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dvz_q, dvz_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   raw_q, raw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               sgn, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     sum, shifted, trial;
  logic [WIDTH-1:0]   quot, rmd;
  logic [2*WIDTH-1:0] prod;

  // For multiply, op_a holds the multiplicand and acc = {partial product, multiplier}.
  // For divide, op_a holds the divisor and acc[WIDTH-1:0] shifts dividend bits out as quotient bits shift in.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dvz_d     = dvz_q;
    op_a_d    = op_a_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    raw_d     = raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    sgn     = ~op_i[0];
    rs_neg  = sgn & rs_data_i[WIDTH-1];
    rt_neg  = sgn & rt_data_i[WIDTH-1];
    rs_mag  = rs_neg ? (~rs_data_i + ONE_W) : rs_data_i;
    rt_mag  = rt_neg ? (~rt_data_i + ONE_W) : rt_data_i;

    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_a_q} : '0);
    shifted = {rem_q, acc_q[WIDTH-1]};
    trial   = shifted - {1'b0, op_a_q};

    quot    = neg_q ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
    rmd     = rem_neg_q ? (~rem_q + ONE_W) : rem_q;
    prod    = neg_q ? (~acc_q + ONE_DW) : acc_q;

    case (state_q)
      IDLE: begin
        if (mthi_i) hi_d = wdata_i;
        if (mtlo_i) lo_d = wdata_i;
        if (start_i) begin
          is_div_d  = op_i[1];
          neg_d     = rs_neg ^ rt_neg;
          rem_neg_d = rs_neg;
          dvz_d     = (rt_data_i == '0);
          raw_d     = rs_data_i;
          rem_d     = '0;
          cnt_d     = 5'd31;
          state_d   = CALC;
          if (op_i[1]) begin
            op_a_d = rt_mag;
            acc_d  = {{WIDTH{1'b0}}, rs_mag};
          end else begin
            op_a_d = rs_mag;
            acc_d  = {{WIDTH{1'b0}}, rt_mag};
          end
        end
      end
      CALC: begin
        if (is_div_q) begin
          // A set top bit of the trial difference means it borrowed, so the shifted remainder is kept.
          rem_d              = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == 5'd0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      FIX: begin
        if (is_div_q) begin
          if (dvz_q) begin
            lo_d = '1;
            hi_d = raw_q;
          end else begin
            lo_d = quot;
            hi_d = rmd;
          end
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dvz_q     <= 1'b0;
      op_a_q    <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      raw_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dvz_q     <= dvz_d;
      op_a_q    <= op_a_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      raw_q     <= raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed self-checking bench for muldiv_hilo_unit: results, latency, done pulse, ignored inputs, reset abort.
module tb_muldiv_hilo_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int compareCount  = 0;
  int mismatchCount = 0;

  muldiv_hilo_unit #(.WIDTH(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .op_i      (op),
    .rs_data_i (rsData),
    .rt_data_i (rtData),
    .mthi_i    (mthi),
    .mtlo_i    (mtlo),
    .wdata_i   (wdata),
    .busy_o    (busy),
    .done_o    (done),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Launches one operation at a negedge and follows it to completion; the bus is sampled on negedges only.
  task automatic applyStimulus(input string tag, input logic [1:0] opSel, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
    logic [31:0] hiBefore, loBefore, hiHeld, loHeld;
    int cyc, doneDuring;
    hiBefore = hi;
    loBefore = lo;
    hiHeld   = 'x;
    loHeld   = 'x;
    @(negedge clk);
    start  = 1'b1;
    op     = opSel;
    rsData = a;
    rtData = b;
    @(negedge clk);
    start      = 1'b0;
    cyc        = 1;
    doneDuring = 0;
    while (busy && cyc < 40) begin
      if (done) doneDuring++;
      if (cyc == 33) begin
        hiHeld = hi;
        loHeld = lo;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, ".busyCycles"}, 32'(cyc - 1), 32'd33);
    checkOutput({tag, ".hiHeld"}, hiHeld, hiBefore);
    checkOutput({tag, ".loHeld"}, loHeld, loBefore);
    checkOutput({tag, ".doneEarly"}, 32'(doneDuring), 32'd0);
    checkOutput({tag, ".done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, ".hi"}, hi, expHi);
    checkOutput({tag, ".lo"}, lo, expLo);
    @(negedge clk);
    checkOutput({tag, ".doneOnce"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cyc, doneCount;
    rst    = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    rsData = '0;
    rtData = '0;
    mthi   = 1'b0;
    mtlo   = 1'b0;
    wdata  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset.busy", {31'd0, busy}, 32'd0);
    checkOutput("reset.done", {31'd0, done}, 32'd0);
    checkOutput("reset.hi", hi, 32'd0);
    checkOutput("reset.lo", lo, 32'd0);

    applyStimulus("mult5x2",   2'b00, 32'd5,          32'd2,          32'h00000000, 32'h0000000A);
    applyStimulus("multNeg",   2'b00, 32'hFFFFFFFD,   32'd7,          32'hFFFFFFFF, 32'hFFFFFFEB);
    applyStimulus("multuMax",  2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001);
    applyStimulus("multuBig",  2'b01, 32'h80000000,   32'd2,          32'h00000001, 32'h00000000);
    applyStimulus("div10by3",  2'b10, 32'd10,         32'd3,          32'h00000001, 32'h00000003);
    applyStimulus("divNeg7by2",2'b10, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD);
    applyStimulus("divOvf",    2'b10, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32'h80000000);
    applyStimulus("divuMax",   2'b11, 32'hFFFFFFFF,   32'd2,          32'h00000001, 32'h7FFFFFFF);
    applyStimulus("divuZero",  2'b11, 32'd9,          32'd0,          32'h00000009, 32'hFFFFFFFF);
    applyStimulus("divNegZero",2'b10, 32'hFFFFFFF7,   32'd0,          32'hFFFFFFF7, 32'hFFFFFFFF);

    // MULT 4x4 launched together with an MTLO, then a second start and MTLO injected while busy.
    @(negedge clk);
    start  = 1'b1;
    op     = 2'b00;
    rsData = 32'd4;
    rtData = 32'd4;
    mtlo   = 1'b1;
    wdata  = 32'h55;
    @(negedge clk);
    start = 1'b0;
    mtlo  = 1'b0;
    cyc   = 1;
    while (busy && cyc < 40) begin
      if (cyc == 1) checkOutput("mtWithStart.lo", lo, 32'h55);
      if (cyc == 5) begin
        start  = 1'b1;
        op     = 2'b10;
        rsData = 32'd8;
        rtData = 32'd2;
        mtlo   = 1'b1;
        wdata  = 32'd7;
      end
      if (cyc == 6) begin
        start = 1'b0;
        mtlo  = 1'b0;
        checkOutput("busyMtlo.lo", lo, 32'h55);
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput("busyIgnore.cycles", 32'(cyc - 1), 32'd33);
    checkOutput("busyIgnore.done", {31'd0, done}, 32'd1);
    checkOutput("busyIgnore.lo", lo, 32'd16);
    checkOutput("busyIgnore.hi", hi, 32'd0);
    @(negedge clk);
    checkOutput("busyIgnore.noQueue", {31'd0, busy}, 32'd0);

    mthi  = 1'b1;
    wdata = 32'h1234;
    @(negedge clk);
    mthi = 1'b0;
    checkOutput("mthiIdle.hi", hi, 32'h1234);
    checkOutput("mthiIdle.lo", lo, 32'd16);

    // Reset lands in the middle of a MULT.
    start  = 1'b1;
    op     = 2'b00;
    rsData = 32'd7;
    rtData = 32'd7;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("midReset.busyBefore", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midReset.busy", {31'd0, busy}, 32'd0);
    checkOutput("midReset.done", {31'd0, done}, 32'd0);
    checkOutput("midReset.hi", hi, 32'd0);
    checkOutput("midReset.lo", lo, 32'd0);
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) doneCount++;
      @(negedge clk);
    end
    checkOutput("midReset.quiet", 32'(doneCount), 32'd0);
    applyStimulus("mult3x3", 2'b00, 32'd3, 32'd3, 32'h00000000, 32'h00000009);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
